// File: rtl/addressed_bus_master.sv
// Purpose : single-outstanding host-side master for addressable_if peripherals;
//           drives address + read/write enables, waits for OR-combined acks,
//           returns a completion or timeout/illegal-direction response.
// Latency : accept at N -> enables at N+1; ack at M -> rsp_valid at M+1 (min 2).
// Backpressure: req_ready only in IDLE; response held until rsp_ready sampled.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        host request handshake
//   req_dir, req_addr          request direction (0 RD, 1 WR, 2 RD+WR, 3 illegal), address
//   rsp_valid/rsp_ready        response handshake
//   rsp_error                  1 = timeout or illegal direction
//   active_address             shared peripheral address
//   read_enable_in, write_enable_in   shared enables to peripherals
//   ack_read, ack_write        OR of peripheral read/write acknowledges
module addressed_bus_master #(
  parameter int ADDRESS_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_dir,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_error,
  output logic [ADDRESS_WIDTH-1:0] active_address,
  output logic                     read_enable_in,
  output logic                     write_enable_in,
  input  logic                     ack_read,
  input  logic                     ack_write
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] DIR_READ        = 2'd0;
  localparam logic [1:0] DIR_WRITE       = 2'd1;
  localparam logic [1:0] DIR_READ_N_WRITE = 2'd2;
  localparam logic [1:0] DIR_ILLEGAL     = 2'd3;

  // Last counter value before the enables are abandoned; the counter is
  // 8 bits wide and never wraps for TIMEOUT_CYCLES in 1..255.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       seen_rd;
  logic       seen_wr;

  logic       want_rd;
  logic       want_wr;
  logic       seen_rd_next;
  logic       seen_wr_next;
  logic       done;

  // Requested direction decoded at accept time.
  assign want_rd = (req_dir == DIR_READ)  || (req_dir == DIR_READ_N_WRITE);
  assign want_wr = (req_dir == DIR_WRITE) || (req_dir == DIR_READ_N_WRITE);

  // In ACTIVE the enable registers themselves record the latched direction,
  // so masking acks with them discards acks for an unrequested direction.
  assign seen_rd_next = seen_rd | (ack_read  & read_enable_in);
  assign seen_wr_next = seen_wr | (ack_write & write_enable_in);

  // Current-cycle acks count toward completion, so an ack arriving on the
  // final timeout cycle still completes cleanly.
  assign done = (!read_enable_in  || seen_rd_next) &&
                (!write_enable_in || seen_wr_next);

  // Held low while reset is asserted so no request looks acceptable then.
  assign req_ready = rst_n && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= 8'd0;
      seen_rd         <= 1'b0;
      seen_wr         <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_error       <= 1'b0;
      active_address  <= '0;
      read_enable_in  <= 1'b0;
      write_enable_in <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            seen_rd <= 1'b0;
            seen_wr <= 1'b0;
            cnt     <= 8'd0;
            if (req_dir == DIR_ILLEGAL) begin
              // Rejected without touching the bus.
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
            end else begin
              state           <= ST_ACTIVE;
              active_address  <= req_addr;
              read_enable_in  <= want_rd;
              write_enable_in <= want_wr;
            end
          end
        end

        ST_ACTIVE: begin
          seen_rd <= seen_rd_next;
          seen_wr <= seen_wr_next;
          if (done) begin
            state           <= ST_RESP;
            read_enable_in  <= 1'b0;
            write_enable_in <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_error       <= 1'b0;
          end else if (cnt == TIMEOUT_LAST) begin
            state           <= ST_RESP;
            read_enable_in  <= 1'b0;
            write_enable_in <= 1'b0;
            rsp_valid       <= 1'b1;
            rsp_error       <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
          end
        end

        default: begin
          state           <= ST_IDLE;
          rsp_valid       <= 1'b0;
          rsp_error       <= 1'b0;
          read_enable_in  <= 1'b0;
          write_enable_in <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addressed_bus_master.sv
// Directed bench for addressed_bus_master: reset values, each direction,
// timeout and ack-on-timeout, illegal direction with held response,
// mid-transaction reset, stale acks, back-to-back transactions.
module tb_addressed_bus_master;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_dir;
  logic [3:0] req_addr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_error;
  logic [3:0] active_address;
  logic       read_enable_in;
  logic       write_enable_in;
  logic       ack_read;
  logic       ack_write;

  int total = 0;
  int bad   = 0;

  addressed_bus_master #(
    .ADDRESS_WIDTH (4),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dir        (req_dir),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_error      (rsp_error),
    .active_address (active_address),
    .read_enable_in (read_enable_in),
    .write_enable_in(write_enable_in),
    .ack_read       (ack_read),
    .ack_write      (ack_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation and driving both happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction. rd_at/wr_at are the 1-based enable cycles on which
  // an ack is pulsed (0 = never). Expected enable pattern, enable-cycle count
  // and error flag are supplied by the caller.
  task automatic do_txn(input string tag, input logic [1:0] dir, input logic [3:0] addr,
                        input int rd_at, input int wr_at,
                        input logic exp_rd, input logic exp_wr,
                        input int exp_cycles, input logic exp_err);
    int  n;
    bit  en_bad;
    chk({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_dir   = dir;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    n      = 0;
    en_bad = 1'b0;
    for (int k = 1; k <= 40 && !rsp_valid; k++) begin
      if (read_enable_in !== exp_rd || write_enable_in !== exp_wr ||
          active_address !== addr || req_ready !== 1'b0)
        en_bad = 1'b1;
      if (read_enable_in || write_enable_in) n++;
      ack_read  = (k == rd_at);
      ack_write = (k == wr_at);
      tick();
    end
    ack_read  = 1'b0;
    ack_write = 1'b0;
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_error"}, rsp_error, exp_err);
    chk({tag, "_en_cycles"}, n, exp_cycles);
    chk({tag, "_en_pattern_bad"}, en_bad, 0);
    chk({tag, "_en_off"}, {read_enable_in, write_enable_in}, 2'b00);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_cleared"}, rsp_valid, 0);
    chk({tag, "_idle_ready"}, req_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_dir   = 2'd0;
    req_addr  = 4'h0;
    rsp_ready = 1'b0;
    ack_read  = 1'b0;
    ack_write = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_addr", active_address, 0);
    chk("rst_enables", {read_enable_in, write_enable_in}, 2'b00);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", req_ready, 1);

    // 1: READ with ack on enable cycle 3
    do_txn("t1_read", 2'd0, 4'h5, 3, 0, 1'b1, 1'b0, 3, 1'b0);

    // 2: READ_N_WRITE, write ack at 1, read ack at 4
    do_txn("t2_rnw", 2'd2, 4'hA, 4, 1, 1'b1, 1'b1, 4, 1'b0);
    // read ack alone never completes a READ_N_WRITE
    do_txn("t2_rnw_rd_only", 2'd2, 4'hB, 1, 0, 1'b1, 1'b1, 15, 1'b1);

    // 3: WRITE timeout, then ack on the final cycle wins
    do_txn("t3_wr_timeout", 2'd1, 4'h4, 0, 0, 1'b0, 1'b1, 15, 1'b1);
    do_txn("t3_wr_last_ack", 2'd1, 4'h4, 0, 15, 1'b0, 1'b1, 15, 1'b0);
    // write ack during a READ is ignored
    do_txn("t3_rd_ignore_wr", 2'd0, 4'h1, 2, 1, 1'b1, 1'b0, 2, 1'b0);

    // 4: illegal direction, response held while rsp_ready low
    req_valid = 1'b1;
    req_dir   = 2'd3;
    req_addr  = 4'h9;
    tick();
    req_valid = 1'b0;
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_error", rsp_error, 1);
    chk("t4_enables", {read_enable_in, write_enable_in}, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_error", rsp_error, 1);
      chk("t4_hold_ready", req_ready, 0);
      chk("t4_hold_enables", {read_enable_in, write_enable_in}, 2'b00);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t4_released", rsp_valid, 0);
    chk("t4_idle_ready", req_ready, 1);

    // 5: reset on the 2nd ACTIVE cycle
    req_valid = 1'b1;
    req_dir   = 2'd0;
    req_addr  = 4'h6;
    tick();
    req_valid = 1'b0;
    chk("t5_active1", read_enable_in, 1);
    tick();
    chk("t5_active2", read_enable_in, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_enables", {read_enable_in, write_enable_in}, 2'b00);
    chk("t5_rst_addr", active_address, 0);
    chk("t5_rst_rsp", rsp_valid, 0);
    chk("t5_rst_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("t5_after_ready", req_ready, 1);
    chk("t5_after_rsp", rsp_valid, 0);
    // stale ack while IDLE must not complete the next READ
    ack_read = 1'b1;
    tick();
    ack_read = 1'b0;
    chk("t5_idle_ack_rsp", rsp_valid, 0);
    do_txn("t5_fresh_read", 2'd0, 4'h2, 3, 0, 1'b1, 1'b0, 3, 1'b0);

    // 6: back-to-back WRITE to 3 then READ to 7
    do_txn("t6_wr3", 2'd1, 4'h3, 0, 1, 1'b0, 1'b1, 1, 1'b0);
    do_txn("t6_rd7", 2'd0, 4'h7, 1, 0, 1'b1, 1'b0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
